// File: rtl/smachine_pkg.sv
// Shared types and constants for the S-Machine memory responder.
package smachine_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 16;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_DATA,
        ST_ACK
    } state_e;

endpackage

// File: rtl/smachine_sp_ram.sv
// Single-port RAM: synchronous write, combinational read of the addressed word.
// Contents are deliberately not reset.
module smachine_sp_ram
    import smachine_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Commit a write on the rising edge when strobed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Read port follows the address so the caller can register it in the same cycle.
    assign rdata = mem_q[addr];

endmodule

// File: rtl/smachine_mem_responder.sv
// Memory-side responder for the S-Machine CPU: instruction fetch, data
// read/write with programmable wait states, CPU step strobe and idle-time loader.
module smachine_mem_responder
    import smachine_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [ADDR_W-1:0] PC,
    input  logic              mem_req,
    input  logic              read_write_memory,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_out_memory,
    output logic [DATA_W-1:0] inst,
    output logic [DATA_W-1:0] data_in_memory,
    output logic              enable,
    output logic              busy,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [7:0]        fetch_cnt
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_e            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [DATA_W-1:0] rdat_q, rdat_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic              lat_rw_q, lat_rw_d;
    logic [DATA_W-1:0] lat_data_q, lat_data_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              wait_done;

    assign wait_done = (wait_q == WS);

    smachine_sp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // RAM port mux: loader in IDLE, PC in FETCH, latched CPU request otherwise.
    // Kept apart from the next-state logic so read data never loops back into it.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = lat_addr_q;
        ram_wdata = lat_data_q;
        case (state_q)
            ST_IDLE: begin
                ram_addr  = load_addr;
                ram_wdata = load_data;
                ram_we    = load_en;
            end
            ST_FETCH: begin
                ram_addr = PC;
            end
            ST_DATA: begin
                ram_we = wait_done && (lat_rw_q == RW_WRITE);
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    // Next-state, wait-counter and output-register updates.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        inst_d     = inst_q;
        rdat_d     = rdat_q;
        fcnt_d     = fcnt_q;
        lat_addr_d = lat_addr_q;
        lat_rw_d   = lat_rw_q;
        lat_data_d = lat_data_q;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                    wait_d  = '0;
                end
            end
            ST_FETCH: begin
                if (wait_done) begin
                    inst_d  = ram_rdata;
                    fcnt_d  = fcnt_q + 8'd1;
                    wait_d  = '0;
                    state_d = ST_ISSUE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_ISSUE: begin
                wait_d = '0;
                if (mem_req) begin
                    lat_addr_d = addr;
                    lat_rw_d   = read_write_memory;
                    lat_data_d = data_out_memory;
                    state_d    = ST_DATA;
                end else if (run) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (wait_done) begin
                    if (lat_rw_q == RW_READ) begin
                        rdat_d = ram_rdata;
                    end
                    wait_d  = '0;
                    state_d = ST_ACK;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_ACK: begin
                wait_d  = '0;
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and register bank; async reset abandons any pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            inst_q     <= '0;
            rdat_q     <= '0;
            fcnt_q     <= '0;
            lat_addr_q <= '0;
            lat_rw_q   <= RW_READ;
            lat_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            inst_q     <= inst_d;
            rdat_q     <= rdat_d;
            fcnt_q     <= fcnt_d;
            lat_addr_q <= lat_addr_d;
            lat_rw_q   <= lat_rw_d;
            lat_data_q <= lat_data_d;
        end
    end

    assign inst           = inst_q;
    assign data_in_memory = rdat_q;
    assign fetch_cnt      = fcnt_q;
    assign enable         = (state_q == ST_ISSUE) || (state_q == ST_ACK);
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_smachine_mem_responder.sv
// Directed bench for smachine_mem_responder with WAIT_STATES = 1.
module tb_smachine_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [7:0]  PC;
    logic        mem_req;
    logic        read_write_memory;
    logic [7:0]  addr;
    logic [15:0] data_out_memory;
    logic [15:0] inst;
    logic [15:0] data_in_memory;
    logic        enable;
    logic        busy;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [15:0] load_data;
    logic [7:0]  fetch_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    smachine_mem_responder #(
        .ADDR_W      (8),
        .DATA_W      (16),
        .WAIT_STATES (1)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .run               (run),
        .PC                (PC),
        .mem_req           (mem_req),
        .read_write_memory (read_write_memory),
        .addr              (addr),
        .data_out_memory   (data_out_memory),
        .inst              (inst),
        .data_in_memory    (data_in_memory),
        .enable            (enable),
        .busy              (busy),
        .load_en           (load_en),
        .load_addr         (load_addr),
        .load_data         (load_data),
        .fetch_cnt         (fetch_cnt)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; PC = '0; mem_req = 1'b0;
        read_write_memory = 1'b0; addr = '0; data_out_memory = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;

        // 1. reset
        tick(); tick();
        chk("rst_inst", inst, 16'h0000);
        chk("rst_din", data_in_memory, 16'h0000);
        chk("rst_enable", {15'd0, enable}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_fcnt", {8'd0, fetch_cnt}, 16'd0);
        rst_n = 1'b1;
        tick();

        // preload program and data words
        load(8'h00, 16'h0401);
        load(8'h01, 16'h0C01);
        load(8'h02, 16'h1111);
        load(8'h20, 16'h5555);

        // 2. load and fetch
        run = 1'b1; PC = 8'h00;
        tick(); chk("f1_en_c1", {15'd0, enable}, 16'd0);
        tick(); chk("f1_en_c2", {15'd0, enable}, 16'd0);
        tick();
        chk("f1_en", {15'd0, enable}, 16'd1);
        chk("f1_inst", inst, 16'h0401);
        chk("f1_fcnt", {8'd0, fetch_cnt}, 16'd1);
        PC = 8'h01;
        tick(); chk("f1_pulse_len", {15'd0, enable}, 16'd0);
        tick();
        tick();
        chk("f2_en", {15'd0, enable}, 16'd1);
        chk("f2_inst", inst, 16'h0C01);
        chk("f2_fcnt", {8'd0, fetch_cnt}, 16'd2);

        // 3. data write, CPU lines change during DATA
        mem_req = 1'b1; read_write_memory = 1'b1; addr = 8'h10; data_out_memory = 16'hBEEF;
        tick();
        chk("wr_data1_en", {15'd0, enable}, 16'd0);
        mem_req = 1'b0; addr = 8'h11; data_out_memory = 16'h1234; read_write_memory = 1'b0;
        tick(); chk("wr_data2_en", {15'd0, enable}, 16'd0);
        tick();
        chk("wr_ack_en", {15'd0, enable}, 16'd1);
        chk("wr_ack_busy", {15'd0, busy}, 16'd1);
        tick(); tick(); tick();
        chk("f3_inst", inst, 16'h0C01);
        chk("f3_fcnt", {8'd0, fetch_cnt}, 16'd3);

        // 4. data read of the word written above
        mem_req = 1'b1; read_write_memory = 1'b0; addr = 8'h10;
        tick(); mem_req = 1'b0;
        tick();
        tick();
        chk("rd_ack_en", {15'd0, enable}, 16'd1);
        chk("rd_data", data_in_memory, 16'hBEEF);
        tick(); tick(); tick();
        chk("rd_hold", data_in_memory, 16'hBEEF);

        // 5. self-modifying write to 0x02, then fetch from 0x02
        mem_req = 1'b1; read_write_memory = 1'b1; addr = 8'h02; data_out_memory = 16'h8000;
        tick(); mem_req = 1'b0; read_write_memory = 1'b0;
        tick(); tick();
        chk("sm_ack_en", {15'd0, enable}, 16'd1);
        PC = 8'h02;
        tick(); tick(); tick();
        chk("sm_inst", inst, 16'h8000);
        chk("sm_fcnt", {8'd0, fetch_cnt}, 16'd5);
        chk("sm_din_hold", data_in_memory, 16'hBEEF);

        // stop: ISSUE with run low returns to IDLE
        run = 1'b0;
        tick();
        chk("stop_busy", {15'd0, busy}, 16'd0);
        chk("stop_en", {15'd0, enable}, 16'd0);

        // 6b. loader strobe while busy is ignored
        run = 1'b1; PC = 8'h02;
        tick();
        load_en = 1'b1; load_addr = 8'h02; load_data = 16'hDEAD;
        tick();
        load_en = 1'b0;
        tick();
        chk("ld_ign_issue1", {15'd0, enable}, 16'd1);
        tick(); tick(); tick();
        chk("ld_ign_inst", inst, 16'h8000);

        // 6a. reset in the middle of a write's DATA phase
        mem_req = 1'b1; read_write_memory = 1'b1; addr = 8'h20; data_out_memory = 16'hAAAA;
        tick();
        mem_req = 1'b0;
        chk("rstw_in_data", {15'd0, busy}, 16'd1);
        rst_n = 1'b0; run = 1'b0;
        #1;
        chk("rstw_en", {15'd0, enable}, 16'd0);
        chk("rstw_busy", {15'd0, busy}, 16'd0);
        chk("rstw_inst", inst, 16'h0000);
        chk("rstw_fcnt", {8'd0, fetch_cnt}, 16'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // fetch 0x20 to see its contents survived
        run = 1'b1; PC = 8'h20;
        begin
            int n = 0;
            while (enable !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            chk("rstw_wait_en", {15'd0, enable}, 16'd1);
        end
        chk("rstw_mem", inst, 16'h5555);
        chk("rstw_fcnt1", {8'd0, fetch_cnt}, 16'd1);
        run = 1'b0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/smachine_mem_responder.md
Name: smachine_mem_responder

Overview:
Memory-side responder for the S-Machine CPU. It holds the unified 256x16 program/data store and answers instruction fetches at PC. It also services the CPU's data accesses (addr, read_write_memory, data_out_memory, data_in_memory). It paces the CPU by pulsing enable once per completed fetch or data transfer, with programmable wait states. A loader port preloads programs while the core is idle.

Parameters:
ADDR_W, 8, address width (memory depth 2^ADDR_W words)
DATA_W, 16, word and instruction width
WAIT_STATES, 1, extra cycles per fetch or data access (0..15)

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
run  in  1  1 = keep stepping the CPU
PC  in  ADDR_W  fetch address from CPU
mem_req  in  1  CPU requests a data access, sampled in ISSUE
read_write_memory  in  1  0 = read, 1 = write
addr  in  ADDR_W  data address
data_out_memory  in  DATA_W  CPU write data
inst  out  DATA_W  fetched instruction (registered)
data_in_memory  out  DATA_W  read data to CPU (registered)
enable  out  1  one-cycle CPU step strobe
busy  out  1  state != IDLE
load_en  in  1  loader write strobe
load_addr  in  ADDR_W  loader address
load_data  in  DATA_W  loader data
fetch_cnt  out  8  count of completed fetches, wraps 255 -> 0

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE; inst = 0, data_in_memory = 0, enable = 0, fetch_cnt = 0, wait counter = 0.
  - Memory contents are not reset.
- FSM states: IDLE, FETCH, ISSUE, DATA, ACK. enable = 1 only in ISSUE and ACK.
- IDLE:
  - load_en = 1 writes mem[load_addr] <= load_data at the clock edge.
  - run = 1 moves to FETCH and clears the wait counter.
- FETCH:
  - The wait counter increments each cycle.
  - When count == WAIT_STATES: inst <= mem[PC], fetch_cnt += 1, move to ISSUE.
  - FETCH therefore lasts WAIT_STATES+1 cycles.
- ISSUE (one cycle, enable = 1):
  - mem_req = 1: latch addr, read_write_memory and data_out_memory into internal registers, then go to DATA.
  - Otherwise: go to FETCH if run, else IDLE.
- DATA (WAIT_STATES+1 cycles, enable = 0), completing on the last cycle:
  - Write: mem[latched addr] <= latched data.
  - Read: data_in_memory <= mem[latched addr].
  - CPU changes to addr, read_write_memory or data_out_memory during DATA have no effect.
- ACK (one cycle, enable = 1):
  - data_in_memory is stable; it holds until the next read completes.
  - Next state is FETCH if run, else IDLE.
- run dropping mid-FETCH or mid-DATA: the current transfer completes, then the FSM returns to IDLE after ISSUE/ACK.
- load_en outside IDLE is ignored; memory is unchanged.
- Write then fetch at the same address: the write commits in DATA before the next FETCH, so the fetch returns the new word.
- Reset asserted mid-DATA: the pending write is discarded, memory is unchanged, and all outputs go to their reset values immediately.
- Addresses use the full ADDR_W range; there is no out-of-range case.

Decomposition:
- Package smachine_pkg holds:
  - state enum (IDLE, FETCH, ISSUE, DATA, ACK)
  - RW_READ = 0, RW_WRITE = 1
  - ADDR_W / DATA_W defaults
- One sub-module, smachine_sp_ram: single-port synchronous RAM with we, addr, wdata, rdata.
- The responder muxes the RAM port between loader (IDLE), PC (FETCH) and latched addr (DATA).

Test Plan (WAIT_STATES = 1):
1. Reset: rst_n = 0 for 2 cycles -> inst = 0x0000, data_in_memory = 0x0000, enable = 0, busy = 0, fetch_cnt = 0.
2. Load and fetch:
   - Stimulus: load mem[0] = 0x0401, mem[1] = 0x0C01; run = 1 with PC = 0; mem_req = 0; PC changed to 1 after the first pulse.
   - Response: enable pulses high for exactly 1 cycle, 3 cycles after run is sampled, with inst = 0x0401. The next pulse, 3 cycles later, shows inst = 0x0C01 and fetch_cnt = 2.
3. Data write:
   - Stimulus: in ISSUE, mem_req = 1, read_write_memory = 1, addr = 0x10, data_out_memory = 0xBEEF.
   - Response: enable low for 2 DATA cycles, then high 1 cycle (ACK). Changing data_out_memory to 0x1234 during DATA leaves mem[0x10] = 0xBEEF.
4. Data read:
   - Stimulus: in ISSUE, mem_req = 1, read_write_memory = 0, addr = 0x10.
   - Response: data_in_memory = 0xBEEF in the ACK cycle, held until the next read.
5. Self-modify: write 0x8000 to addr = 0x02 while PC steps 1 -> 2 -> the following fetch returns inst = 0x8000.
6. Reset and loader-ignore:
   - Reset case: rst_n = 0 during DATA of a write of 0xAAAA to 0x20 (mem[0x20] preloaded 0x5555) -> mem[0x20] reads 0x5555, enable = 0 and busy = 0 at once.
   - Loader case: load_en = 1 while busy -> the target word is unchanged.
